// File: rtl/vec_packet_tx.sv
// rtl/vec_packet_tx.sv - captures a 3-packet vector and serialises it one packet per handshake
// Optional VEC_PACKET_TX_CHECKSUM_EN appends a fourth XOR checksum beat.
module vec_packet_tx (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] io_inPacket_tx_header_0,
    input  logic [15:0] io_inPacket_tx_addr_0,
    input  logic [31:0] io_inPacket_tx_data_0,
    input  logic [15:0] io_inPacket_tx_header_1,
    input  logic [15:0] io_inPacket_tx_addr_1,
    input  logic [31:0] io_inPacket_tx_data_1,
    input  logic [15:0] io_inPacket_tx_header_2,
    input  logic [15:0] io_inPacket_tx_addr_2,
    input  logic [31:0] io_inPacket_tx_data_2,
    input  logic        io_inValid,
    output logic        io_inReady,
    output logic [15:0] io_out_header,
    output logic [15:0] io_out_addr,
    output logic [31:0] io_out_data,
    output logic        io_outValid,
    output logic        io_outLast,
    input  logic        io_outReady,
    output logic [7:0]  io_txCount
);

`ifdef VEC_PACKET_TX_CHECKSUM_EN
    localparam logic [1:0]  LAST_IDX = 2'd3;
    localparam logic [15:0] CSUM_HDR = 16'hC5C5;
`else
    localparam logic [1:0]  LAST_IDX = 2'd2;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      state_q;
    logic [1:0]  idx_q;
    logic [15:0] hdr_q  [3];
    logic [15:0] addr_q [3];
    logic [31:0] data_q [3];

    logic        in_ready_q;
    logic        out_valid_q;
    logic        out_last_q;
    logic [15:0] out_hdr_q;
    logic [15:0] out_addr_q;
    logic [31:0] out_data_q;
    logic [7:0]  tx_count_q;

    logic [1:0]  nxt_idx_d;
    logic [15:0] beat_hdr_d;
    logic [15:0] beat_addr_d;
    logic [31:0] beat_data_d;

    // Fields of the beat that follows the current one, preloaded into the output registers on transfer.
    always_comb begin
        nxt_idx_d   = idx_q + 2'd1;
        beat_hdr_d  = '0;
        beat_addr_d = '0;
        beat_data_d = '0;
        case (nxt_idx_d)
            2'd0: begin
                beat_hdr_d  = hdr_q[0];
                beat_addr_d = addr_q[0];
                beat_data_d = data_q[0];
            end
            2'd1: begin
                beat_hdr_d  = hdr_q[1];
                beat_addr_d = addr_q[1];
                beat_data_d = data_q[1];
            end
            2'd2: begin
                beat_hdr_d  = hdr_q[2];
                beat_addr_d = addr_q[2];
                beat_data_d = data_q[2];
            end
`ifdef VEC_PACKET_TX_CHECKSUM_EN
            2'd3: begin
                beat_hdr_d  = CSUM_HDR;
                beat_addr_d = addr_q[0] ^ addr_q[1] ^ addr_q[2];
                beat_data_d = data_q[0] ^ data_q[1] ^ data_q[2];
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            for (int k = 0; k < 3; k++) begin
                hdr_q[k]  <= '0;
                addr_q[k] <= '0;
                data_q[k] <= '0;
            end
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_hdr_q   <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            tx_count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (io_inValid) begin
                        hdr_q[0]    <= io_inPacket_tx_header_0;
                        hdr_q[1]    <= io_inPacket_tx_header_1;
                        hdr_q[2]    <= io_inPacket_tx_header_2;
                        addr_q[0]   <= io_inPacket_tx_addr_0;
                        addr_q[1]   <= io_inPacket_tx_addr_1;
                        addr_q[2]   <= io_inPacket_tx_addr_2;
                        data_q[0]   <= io_inPacket_tx_data_0;
                        data_q[1]   <= io_inPacket_tx_data_1;
                        data_q[2]   <= io_inPacket_tx_data_2;
                        idx_q       <= 2'd0;
                        out_hdr_q   <= io_inPacket_tx_header_0;
                        out_addr_q  <= io_inPacket_tx_addr_0;
                        out_data_q  <= io_inPacket_tx_data_0;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        in_ready_q  <= 1'b0;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    if (out_valid_q && io_outReady) begin
                        if (idx_q == LAST_IDX) begin
                            state_q     <= IDLE;
                            idx_q       <= 2'd0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_hdr_q   <= '0;
                            out_addr_q  <= '0;
                            out_data_q  <= '0;
                            in_ready_q  <= 1'b1;
                            tx_count_q  <= tx_count_q + 8'd1;
                        end else begin
                            idx_q       <= nxt_idx_d;
                            out_hdr_q   <= beat_hdr_d;
                            out_addr_q  <= beat_addr_d;
                            out_data_q  <= beat_data_d;
                            out_last_q  <= (nxt_idx_d == LAST_IDX);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io_inReady    = in_ready_q;
    assign io_outValid   = out_valid_q;
    assign io_outLast    = out_last_q;
    assign io_out_header = out_hdr_q;
    assign io_out_addr   = out_addr_q;
    assign io_out_data   = out_data_q;
    assign io_txCount    = tx_count_q;

endmodule

// File: tb/tb_vec_packet_tx.sv
// tb/tb_vec_packet_tx.sv - randomized self-checking bench for vec_packet_tx
module tb_vec_packet_tx;

`ifdef VEC_PACKET_TX_CHECKSUM_EN
    localparam int NBEATS = 4;
`else
    localparam int NBEATS = 3;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] h0, h1, h2, a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic        io_inValid, io_inReady, io_outValid, io_outLast, io_outReady;
    logic [15:0] io_out_header, io_out_addr;
    logic [31:0] io_out_data;
    logic [7:0]  io_txCount;

    always #5 clock = ~clock;

    vec_packet_tx dut (
        .clock(clock), .reset(reset),
        .io_inPacket_tx_header_0(h0), .io_inPacket_tx_addr_0(a0), .io_inPacket_tx_data_0(d0),
        .io_inPacket_tx_header_1(h1), .io_inPacket_tx_addr_1(a1), .io_inPacket_tx_data_1(d1),
        .io_inPacket_tx_header_2(h2), .io_inPacket_tx_addr_2(a2), .io_inPacket_tx_data_2(d2),
        .io_inValid(io_inValid), .io_inReady(io_inReady),
        .io_out_header(io_out_header), .io_out_addr(io_out_addr), .io_out_data(io_out_data),
        .io_outValid(io_outValid), .io_outLast(io_outLast), .io_outReady(io_outReady),
        .io_txCount(io_txCount)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int tx_exp   = 0;

    // Vector handed to the DUT, and what the link side observed for it.
    logic [15:0] vh [3];
    logic [15:0] va [3];
    logic [31:0] vd [3];
    logic [15:0] oh [4];
    logic [15:0] oa [4];
    logic [31:0] od [4];
    logic        ol [4];
    int          nobs, cyc, hold_err, first_delay;
    bit          timeout;
    logic        after_in_ready, after_valid;
    logic [7:0]  after_cnt;

    function automatic logic [15:0] exp_h(int k);
        return (k < 3) ? vh[k] : 16'hC5C5;
    endfunction
    function automatic logic [15:0] exp_a(int k);
        return (k < 3) ? va[k] : (va[0] ^ va[1] ^ va[2]);
    endfunction
    function automatic logic [31:0] exp_d(int k);
        return (k < 3) ? vd[k] : (vd[0] ^ vd[1] ^ vd[2]);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rand_vec();
        for (int k = 0; k < 3; k++) begin
            vh[k] = 16'($urandom);
            va[k] = 16'($urandom);
            vd[k] = $urandom;
        end
    endtask

    task automatic drive_vec();
        h0 = vh[0]; h1 = vh[1]; h2 = vh[2];
        a0 = va[0]; a1 = va[1]; a2 = va[2];
        d0 = vd[0]; d1 = vd[1]; d2 = vd[2];
    endtask

    task automatic scramble_inputs();
        h0 = 16'($urandom); h1 = 16'($urandom); h2 = 16'($urandom);
        a0 = 16'($urandom); a1 = 16'($urandom); a2 = 16'($urandom);
        d0 = $urandom;      d1 = $urandom;      d2 = $urandom;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        io_inValid = 1'b0;
        tick();
        reset = 1'b1;
        tx_exp = 0;
    endtask

    // Drives one vector and records every transferred beat; mode 0 ready=1, 1 random ready, 2 five-cycle stall on beat 1.
    task automatic run_vector(input int mode, input bit garbage);
        logic [15:0] sh, sa;
        logic [31:0] sd;
        bit held, done, rdy;
        int stall_left;
        nobs = 0; cyc = 0; hold_err = 0; first_delay = -1; timeout = 0;
        held = 0; done = 0; stall_left = 5;
        sh = '0; sa = '0; sd = '0;
        drive_vec();
        io_inValid  = 1'b1;
        io_outReady = 1'b1;
        tick();
        if (garbage) scramble_inputs();
        else io_inValid = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (first_delay < 0 && io_outValid) first_delay = c + 1;
            if (held && (io_out_header !== sh || io_out_addr !== sa ||
                         io_out_data !== sd || io_outValid !== 1'b1))
                hold_err++;
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = 1'($urandom_range(0, 1));
            else if (nobs == 1 && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else rdy = 1'b1;
            io_outReady = rdy;
            held = 0;
            if (io_outValid && rdy) begin
                if (nobs < 4) begin
                    oh[nobs] = io_out_header;
                    oa[nobs] = io_out_addr;
                    od[nobs] = io_out_data;
                    ol[nobs] = io_outLast;
                end
                nobs++;
                if (io_outLast || nobs > 4) begin
                    done = 1;
                    io_inValid = 1'b0;
                end
            end else if (io_outValid) begin
                held = 1;
                sh = io_out_header; sa = io_out_addr; sd = io_out_data;
            end
            if (garbage && !done) scramble_inputs();
            cyc++;
            tick();
        end
        if (!done) timeout = 1;
        io_inValid     = 1'b0;
        io_outReady    = 1'b1;
        after_in_ready = io_inReady;
        after_valid    = io_outValid;
        after_cnt      = io_txCount;
    endtask

    task automatic test_reset();
        rand_vec();
        drive_vec();
        reset       = 1'b0;
        io_inValid  = 1'b1;
        io_outReady = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({io_inReady, io_outValid, io_outLast} !== 3'b100) $display("FAIL reset_flags got %b want 100", {io_inReady, io_outValid, io_outLast});
        else n_pass++;
        n_checks++;
        if ({io_out_header, io_out_addr, io_out_data, io_txCount} !== 72'd0) $display("FAIL reset_fields got %h %h %h %h want 0", io_out_header, io_out_addr, io_out_data, io_txCount);
        else n_pass++;
        reset = 1'b1;
        io_inValid = 1'b0;
        tick();
        n_checks++;
        if ({io_inReady, io_outValid, io_out_header} !== {2'b10, 16'h0}) $display("FAIL idle_after_reset got rdy=%b vld=%b hdr=%h want 1 0 0", io_inReady, io_outValid, io_out_header);
        else n_pass++;
        tx_exp = 0;
    endtask

    task automatic test_basic();
        for (int k = 0; k < 3; k++) begin
            vh[k] = 16'h10 + 16'(k);
            va[k] = 16'h200 + 16'(k);
            vd[k] = 32'hA000_0000 + 32'(k);
        end
        run_vector(0, 0);
        tx_exp = (tx_exp + 1) % 256;
        n_checks++;
        if (timeout || nobs != NBEATS) $display("FAIL basic_beats got %0d timeout=%0d want %0d", nobs, timeout, NBEATS);
        else n_pass++;
        n_checks++;
        if (first_delay != 1) $display("FAIL basic_latency got %0d want 1", first_delay);
        else n_pass++;
        for (int k = 0; k < NBEATS && k < nobs && k < 4; k++) begin
            n_checks++;
            if ({oh[k], oa[k], od[k], ol[k]} !== {exp_h(k), exp_a(k), exp_d(k), 1'(k == NBEATS - 1)})
                $display("FAIL basic_beat%0d got %h %h %h %b want %h %h %h %b", k, oh[k], oa[k], od[k], ol[k], exp_h(k), exp_a(k), exp_d(k), k == NBEATS - 1);
            else n_pass++;
        end
        n_checks++;
        if (cyc != NBEATS) $display("FAIL basic_no_bubbles got %0d cycles want %0d", cyc, NBEATS);
        else n_pass++;
        n_checks++;
        if ({after_in_ready, after_valid, after_cnt} !== {2'b10, 8'(tx_exp)}) $display("FAIL basic_after got rdy=%b vld=%b cnt=%0d want 1 0 %0d", after_in_ready, after_valid, after_cnt, tx_exp);
        else n_pass++;
        n_checks++;
        if ({io_out_header, io_out_addr, io_out_data} !== 64'd0) $display("FAIL idle_fields_zero got %h %h %h want 0", io_out_header, io_out_addr, io_out_data);
        else n_pass++;
    endtask

    task automatic test_stall();
        for (int k = 0; k < 3; k++) begin
            vh[k] = 16'h10 + 16'(k);
            va[k] = 16'h200 + 16'(k);
            vd[k] = 32'hA000_0000 + 32'(k);
        end
        run_vector(2, 0);
        tx_exp = (tx_exp + 1) % 256;
        n_checks++;
        if (hold_err != 0) $display("FAIL stall_hold got %0d changes want 0", hold_err);
        else n_pass++;
        n_checks++;
        if (timeout || nobs != NBEATS || cyc != NBEATS + 5) $display("FAIL stall_count got beats=%0d cycles=%0d want %0d %0d", nobs, cyc, NBEATS, NBEATS + 5);
        else n_pass++;
        for (int k = 0; k < NBEATS && k < nobs && k < 4; k++) begin
            n_checks++;
            if ({oh[k], oa[k], od[k]} !== {exp_h(k), exp_a(k), exp_d(k)})
                $display("FAIL stall_beat%0d got %h %h %h want %h %h %h", k, oh[k], oa[k], od[k], exp_h(k), exp_a(k), exp_d(k));
            else n_pass++;
        end
    endtask

    task automatic test_random(input int nvec, input bit garbage);
        int bad;
        bad = 0;
        for (int v = 0; v < nvec; v++) begin
            rand_vec();
            run_vector(1, garbage);
            tx_exp = (tx_exp + 1) % 256;
            if (timeout || nobs != NBEATS || hold_err != 0 || after_cnt !== 8'(tx_exp)) bad++;
            else
                for (int k = 0; k < NBEATS; k++)
                    if ({oh[k], oa[k], od[k], ol[k]} !== {exp_h(k), exp_a(k), exp_d(k), 1'(k == NBEATS - 1)}) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL random_vectors garbage=%0d got %0d bad vectors want 0", garbage, bad);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int bad_beats, bad_cycles, bad_cnt;
        bad_beats = 0; bad_cycles = 0; bad_cnt = 0;
        apply_reset();
        for (int v = 0; v < 256; v++) begin
            rand_vec();
            run_vector(0, 0);
            tx_exp = (tx_exp + 1) % 256;
            if (timeout || cyc != NBEATS || after_in_ready !== 1'b1) bad_cycles++;
            if (after_cnt !== 8'(tx_exp)) bad_cnt++;
            for (int k = 0; k < NBEATS && k < nobs && k < 4; k++)
                if ({oh[k], oa[k], od[k]} !== {exp_h(k), exp_a(k), exp_d(k)}) bad_beats++;
            if (v == 254) begin
                n_checks++;
                if (after_cnt !== 8'd255) $display("FAIL b2b_count255 got %0d want 255", after_cnt);
                else n_pass++;
            end
        end
        n_checks++;
        if (after_cnt !== 8'd0) $display("FAIL b2b_wrap got %0d want 0", after_cnt);
        else n_pass++;
        n_checks++;
        if (bad_cycles != 0) $display("FAIL b2b_period got %0d bad vectors want 0", bad_cycles);
        else n_pass++;
        n_checks++;
        if (bad_beats != 0 || bad_cnt != 0) $display("FAIL b2b_data got %0d bad beats %0d bad counts want 0 0", bad_beats, bad_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid_send();
        apply_reset();
        rand_vec();
        drive_vec();
        io_inValid  = 1'b1;
        io_outReady = 1'b1;
        tick();
        io_inValid = 1'b0;
        tick();
        n_checks++;
        if ({io_outValid, io_out_header} !== {1'b1, vh[1]}) $display("FAIL midreset_beat1 got vld=%b hdr=%h want 1 %h", io_outValid, io_out_header, vh[1]);
        else n_pass++;
        reset = 1'b0;
        io_inValid = 1'b1;
        tick();
        n_checks++;
        if ({io_outValid, io_inReady, io_outLast, io_txCount, io_out_header} !== {3'b010, 8'd0, 16'd0})
            $display("FAIL midreset_discard got vld=%b rdy=%b last=%b cnt=%0d hdr=%h want 0 1 0 0 0", io_outValid, io_inReady, io_outLast, io_txCount, io_out_header);
        else n_pass++;
        reset = 1'b1;
        io_inValid = 1'b0;
        tx_exp = 0;
        rand_vec();
        run_vector(0, 0);
        tx_exp = (tx_exp + 1) % 256;
        n_checks++;
        if (timeout || nobs != NBEATS || {oh[0], oa[0], od[0]} !== {vh[0], va[0], vd[0]} || after_cnt !== 8'd1)
            $display("FAIL midreset_restart got beats=%0d hdr0=%h cnt=%0d want %0d %h 1", nobs, oh[0], after_cnt, NBEATS, vh[0]);
        else n_pass++;
    endtask

`ifdef VEC_PACKET_TX_CHECKSUM_EN
    task automatic test_checksum();
        for (int k = 0; k < 3; k++) vh[k] = 16'($urandom);
        va[0] = 16'h0001; va[1] = 16'h0002; va[2] = 16'h0004;
        vd[0] = 32'h1;    vd[1] = 32'h2;    vd[2] = 32'h4;
        run_vector(0, 0);
        tx_exp = (tx_exp + 1) % 256;
        n_checks++;
        if (timeout || nobs != 4) $display("FAIL csum_beats got %0d want 4", nobs);
        else n_pass++;
        n_checks++;
        if ({oh[3], oa[3], od[3], ol[3]} !== {16'hC5C5, 16'h0007, 32'h7, 1'b1})
            $display("FAIL csum_beat got %h %h %h %b want c5c5 0007 00000007 1", oh[3], oa[3], od[3], ol[3]);
        else n_pass++;
        n_checks++;
        if (ol[2] !== 1'b0) $display("FAIL csum_beat2_last got %b want 0", ol[2]);
        else n_pass++;
    endtask
`endif

    initial begin
        reset = 1'b1;
        io_inValid = 1'b0;
        io_outReady = 1'b1;
        scramble_inputs();
        test_reset();
        test_basic();
        test_stall();
        test_random(20, 1'b0);
        test_random(20, 1'b1);
        test_back_to_back();
        test_reset_mid_send();
`ifdef VEC_PACKET_TX_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
